// File: rtl/video_timing_pkg.sv
// Shared raster-timing helpers and the sync/de bundle carried down the delay line.
package video_timing_pkg;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } timing_t;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(int active, int fp, int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster/timing bundle from the timing core to the painter, game logic and VGA pins.
interface video_timing_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic [X_W-1:0] beam_x;
  logic [Y_W-1:0] beam_y;
  logic           valid;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic           frame_start;
  logic           vblank_start;
  logic           tick;
  logic           tick_missed;

  modport master (output beam_x, beam_y, valid, hsync, vsync, de,
                  frame_start, vblank_start, tick, tick_missed);
  modport slave  (input  beam_x, beam_y, valid, hsync, vsync, de,
                  frame_start, vblank_start, tick, tick_missed);
endinterface

// File: rtl/video_timing_core_sync_delay_line.sv
// Reset-clearable shift register; DEPTH=0 collapses to a plain wire.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= {DEPTH{RST_VAL}};
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_core.sv
// Raster counters, sync/de generation and the game-update tick. Coordinates lead
// the pins by PIPE cycles so a registered painter lines up without compensation.
module video_timing_core
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int PIPE        = 2,
  parameter int TICK_PERIOD = 138888,
  parameter bit TICK_SYNC   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  video_timing_if.master vid_o
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int TC_W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  // One spare bit so window ends equal to 2^X_W / 2^Y_W still compare correctly.
  localparam logic [X_W:0] H_LAST = (X_W+1)'(H_TOTAL - 1);
  localparam logic [X_W:0] H_ACT  = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0] HS_BEG = (X_W+1)'(sync_start(H_ACTIVE, H_FP));
  localparam logic [X_W:0] HS_END = (X_W+1)'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [Y_W:0] V_LAST = (Y_W+1)'(V_TOTAL - 1);
  localparam logic [Y_W:0] V_ACT  = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] VS_BEG = (Y_W+1)'(sync_start(V_ACTIVE, V_FP));
  localparam logic [Y_W:0] VS_END = (Y_W+1)'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_PERIOD - 1);

  if (H_TOTAL > (1 << X_W)) begin : g_chk_h
    $error("H_TOTAL does not fit in X_W bits");
  end
  if (V_TOTAL > (1 << Y_W)) begin : g_chk_v
    $error("V_TOTAL does not fit in Y_W bits");
  end
  if (TICK_PERIOD < 1) begin : g_chk_t
    $error("TICK_PERIOD must be at least 1");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_chk_p
    $error("PIPE must lie in 0..7");
  end

  logic [X_W-1:0]  hc_q, hc_d;
  logic [Y_W-1:0]  vc_q, vc_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic            pending_q, pending_d;
  logic            missed_q, missed_d;
  logic [X_W:0]    hx;
  logic [Y_W:0]    vx;
  logic            h_wrap, period_evt, valid, frame_start, vblank_start, tick;
  timing_t         raw, dly;

  assign hx = {1'b0, hc_q};
  assign vx = {1'b0, vc_q};

  always_comb begin
    h_wrap     = (hx == H_LAST);
    hc_d       = h_wrap ? '0 : hc_q + 1'b1;
    vc_d       = vc_q;
    if (h_wrap) vc_d = (vx == V_LAST) ? '0 : vc_q + 1'b1;
    period_evt = (tc_q == TC_LAST);
    tc_d       = period_evt ? '0 : tc_q + 1'b1;
  end

  assign valid        = (hx < H_ACT) && (vx < V_ACT);
  assign frame_start  = (hc_q == '0) && (vc_q == '0);
  assign vblank_start = (hc_q == '0) && (vx == V_ACT);

  always_comb begin
    pending_d = pending_q;
    missed_d  = missed_q;
    tick      = period_evt;
    if (TICK_SYNC) begin
      tick = vblank_start && (pending_q || period_evt);
      // A fresh period event landing on a flush that already owed a tick stays queued.
      if (vblank_start) begin
        pending_d = pending_q && period_evt;
      end else begin
        pending_d = pending_q || period_evt;
        missed_d  = missed_q || (pending_q && period_evt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q      <= '0;
      vc_q      <= '0;
      tc_q      <= '0;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      tc_q      <= tc_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  // Sync levels travel active-high; pin polarity is applied after the delay.
  always_comb begin
    raw.hsync = (hx >= HS_BEG) && (hx < HS_END);
    raw.vsync = (vx >= VS_BEG) && (vx < VS_END);
    raw.de    = valid;
  end

  sync_delay_line #(
    .WIDTH   ($bits(timing_t)),
    .DEPTH   (PIPE),
    .RST_VAL ('0)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i (raw),
    .q_o (dly)
  );

  assign vid_o.beam_x       = hc_q;
  assign vid_o.beam_y       = vc_q;
  assign vid_o.valid        = valid;
  assign vid_o.hsync        = HS_POL ? dly.hsync : ~dly.hsync;
  assign vid_o.vsync        = VS_POL ? dly.vsync : ~dly.vsync;
  assign vid_o.de           = dly.de;
  assign vid_o.frame_start  = frame_start;
  assign vid_o.vblank_start = vblank_start;
  assign vid_o.tick         = tick;
  assign vid_o.tick_missed  = missed_q;

endmodule

// File: tb/tb_video_timing_core.sv
// Three timing cores (wide/PIPE=3/free tick, small/deferred tick, small/aligned tick)
// checked each cycle against an arithmetic raster model, plus literal anchors.
module tb_video_timing_core;

  typedef struct {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, pipe, hpol, vpol, per, tsync;
  } cfg_t;

  typedef struct {
    int bx, by, valid, hs, vs, de, fs, vbs, tick, miss;
  } out_t;

  cfg_t CA = '{640, 16, 96, 48, 6, 1, 2, 1, 3, 0, 0, 1000, 0};
  cfg_t CB = '{12, 2, 3, 3, 8, 1, 1, 0, 1, 1, 1, 50, 1};
  cfg_t CC = '{12, 2, 3, 3, 8, 1, 1, 0, 2, 0, 0, 161, 1};

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0, phase = 0, n_chk = 0, n_fail = 0;
  int   pend [3];
  int   miss [3];
  int   hs_low_a = 0, vs_low_a = 0, de_a = 0, fs_a = 0, tick_a = 0, tick_b = 0;
  int   fs2_a = -1, tick1_a = -1, x656_a = -1, hsf_a = -1, de1_a = -1;
  int   tick1_b = -1, miss1_b = -1, tick1_c = -1, miss1_c = -1;

  always #5 clk = ~clk;

  video_timing_if #(.X_W(11), .Y_W(10)) ifa ();
  video_timing_if #(.X_W(11), .Y_W(10)) ifb ();
  video_timing_if #(.X_W(11), .Y_W(10)) ifc ();

  video_timing_core #(
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE(3), .TICK_PERIOD(1000), .TICK_SYNC(1'b0)
  ) u_a (.clk(clk), .rst(rst), .vid_o(ifa));

  video_timing_core #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(0),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .PIPE(1), .TICK_PERIOD(50), .TICK_SYNC(1'b1)
  ) u_b (.clk(clk), .rst(rst), .vid_o(ifb));

  video_timing_core #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(0),
    .PIPE(2), .TICK_PERIOD(161), .TICK_SYNC(1'b1)
  ) u_c (.clk(clk), .rst(rst), .vid_o(ifc));

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Raster position of cycle c is plain div/mod; pins show the raster of c-PIPE.
  function automatic out_t model(cfg_t g, int c);
    out_t o;
    int ht, vt, d, x, y;
    ht = g.ha + g.hfp + g.hsy + g.hbp;
    vt = g.va + g.vfp + g.vsy + g.vbp;
    o.bx    = c % ht;
    o.by    = (c / ht) % vt;
    o.valid = int'(o.bx < g.ha && o.by < g.va);
    o.fs    = int'(o.bx == 0 && o.by == 0);
    o.vbs   = int'(o.bx == 0 && o.by == g.va);
    o.hs    = 1 - g.hpol;
    o.vs    = 1 - g.vpol;
    o.de    = 0;
    if (c >= g.pipe) begin
      d = c - g.pipe;
      x = d % ht;
      y = (d / ht) % vt;
      if (x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsy) o.hs = g.hpol;
      if (y >= g.va + g.vfp && y < g.va + g.vfp + g.vsy) o.vs = g.vpol;
      o.de = int'(x < g.ha && y < g.va);
    end
    o.tick = int'(c % g.per == g.per - 1);
    o.miss = 0;
    return o;
  endfunction

  task automatic check_inst(int k, string nm, cfg_t g, out_t a);
    out_t e;
    bit   period;
    e      = model(g, cyc);
    period = (cyc % g.per == g.per - 1);
    if (g.tsync != 0) e.tick = int'(e.vbs != 0 && (pend[k] != 0 || period));
    e.miss = miss[k];
    chk({nm, ".beam_x"}, a.bx, e.bx);
    chk({nm, ".beam_y"}, a.by, e.by);
    chk({nm, ".valid"}, a.valid, e.valid);
    chk({nm, ".hsync"}, a.hs, e.hs);
    chk({nm, ".vsync"}, a.vs, e.vs);
    chk({nm, ".de"}, a.de, e.de);
    chk({nm, ".frame_start"}, a.fs, e.fs);
    chk({nm, ".vblank_start"}, a.vbs, e.vbs);
    chk({nm, ".tick"}, a.tick, e.tick);
    chk({nm, ".tick_missed"}, a.miss, e.miss);
    if (g.tsync != 0) begin
      if (e.vbs != 0) begin
        pend[k] = int'(pend[k] != 0 && period);
      end else if (period) begin
        if (pend[k] != 0) miss[k] = 1;
        pend[k] = 1;
      end
    end
  endtask

  task automatic check_rst(string nm, cfg_t g, out_t a);
    chk({nm, ".rst_beam_x"}, a.bx, 0);
    chk({nm, ".rst_beam_y"}, a.by, 0);
    chk({nm, ".rst_valid"}, a.valid, 1);
    chk({nm, ".rst_frame_start"}, a.fs, 1);
    chk({nm, ".rst_de"}, a.de, 0);
    chk({nm, ".rst_hsync"}, a.hs, 1 - g.hpol);
    chk({nm, ".rst_vsync"}, a.vs, 1 - g.vpol);
    chk({nm, ".rst_tick"}, a.tick, 0);
    chk({nm, ".rst_tick_missed"}, a.miss, 0);
  endtask

  always @(negedge clk) begin
    out_t aa, ab, ac;
    aa = '{int'(ifa.beam_x), int'(ifa.beam_y), int'(ifa.valid), int'(ifa.hsync),
           int'(ifa.vsync), int'(ifa.de), int'(ifa.frame_start), int'(ifa.vblank_start),
           int'(ifa.tick), int'(ifa.tick_missed)};
    ab = '{int'(ifb.beam_x), int'(ifb.beam_y), int'(ifb.valid), int'(ifb.hsync),
           int'(ifb.vsync), int'(ifb.de), int'(ifb.frame_start), int'(ifb.vblank_start),
           int'(ifb.tick), int'(ifb.tick_missed)};
    ac = '{int'(ifc.beam_x), int'(ifc.beam_y), int'(ifc.valid), int'(ifc.hsync),
           int'(ifc.vsync), int'(ifc.de), int'(ifc.frame_start), int'(ifc.vblank_start),
           int'(ifc.tick), int'(ifc.tick_missed)};
    if (rst) begin
      cyc  = 0;
      pend = '{0, 0, 0};
      miss = '{0, 0, 0};
      check_rst("a", CA, aa);
      check_rst("b", CB, ab);
      check_rst("c", CC, ac);
    end else begin
      check_inst(0, "a", CA, aa);
      check_inst(1, "b", CB, ab);
      check_inst(2, "c", CC, ac);
      if (phase == 0 && cyc < 16000) begin
        if (aa.hs == 0) hs_low_a++;
        if (aa.vs == 0) vs_low_a++;
        if (aa.de != 0) de_a++;
        if (aa.fs != 0) begin
          fs_a++;
          if (cyc > 0 && fs2_a < 0) fs2_a = cyc;
        end
        if (aa.tick != 0) begin
          tick_a++;
          if (tick1_a < 0) tick1_a = cyc;
        end
        if (aa.bx == 656 && x656_a < 0) x656_a = cyc;
        if (aa.hs == 0 && hsf_a < 0) hsf_a = cyc;
        if (aa.de != 0 && de1_a < 0) de1_a = cyc;
        if (ab.tick != 0) begin
          tick_b++;
          if (tick1_b < 0) tick1_b = cyc;
        end
        if (ab.miss != 0 && miss1_b < 0) miss1_b = cyc;
        if (ac.tick != 0 && tick1_c < 0) tick1_c = cyc;
        if (ac.miss != 0 && miss1_c < 0) miss1_c = cyc;
      end
      cyc++;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Two full frames of u_a (8000 clocks each) are tallied, then run on to hc=700, vc=8.
    repeat (23100) @(posedge clk);
    #2;
    chk("a.pre_rst_beam_x", int'(ifa.beam_x), 700);
    chk("a.pre_rst_beam_y", int'(ifa.beam_y), 8);
    chk("a.pre_rst_hsync", int'(ifa.hsync), 0);
    chk("a.pre_rst_vsync", int'(ifa.vsync), 0);
    chk("b.pre_rst_tick_missed", int'(ifb.tick_missed), 1);

    chk("a.hsync_low_cycles", hs_low_a, 1920);
    chk("a.vsync_low_cycles", vs_low_a, 3200);
    chk("a.de_high_cycles", de_a, 7680);
    chk("a.frame_start_count", fs_a, 2);
    chk("a.frame_period", fs2_a, 8000);
    chk("a.first_tick", tick1_a, 999);
    chk("a.tick_count", tick_a, 16);
    chk("a.hc656_cycle", x656_a, 656);
    chk("a.hsync_fall_cycle", hsf_a, 659);
    chk("a.de_rise_cycle", de1_a, 3);
    chk("b.first_tick", tick1_b, 160);
    chk("b.tick_count", tick_b, 80);
    chk("b.first_missed", miss1_b, 100);
    chk("c.first_tick", tick1_c, 160);
    chk("c.first_missed", miss1_c, 1127);

    phase = 1;
    rst   = 1'b1;
    #1;
    chk("a.mid_rst_hsync", int'(ifa.hsync), 1);
    chk("a.mid_rst_vsync", int'(ifa.vsync), 1);
    chk("a.mid_rst_beam_x", int'(ifa.beam_x), 0);
    chk("b.mid_rst_tick_missed", int'(ifb.tick_missed), 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("a.post_rst_frame_start", int'(ifa.frame_start), 1);
    chk("a.post_rst_hsync", int'(ifa.hsync), 1);
    chk("b.post_rst_tick_missed", int'(ifb.tick_missed), 0);
    repeat (600) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
